// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// Holds the FSM state encoding and the port index values used for grants.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone requester wins; on a tie the port
// that was not served last wins.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        grant = PORT_CPU;
        valid = |req;
        case (req)
            2'b01:   grant = PORT_CPU;
            2'b10:   grant = PORT_DMA;
            2'b11:   grant = ~last;
            default: grant = PORT_CPU;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates a CPU port and a DMA port onto one data memory using a
// three-state IDLE/SERVE/ACK sequence, one access every three cycles.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last;
    logic                r_gnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dma_rdata;
    logic                w_grant;
    logic                w_valid;

    rr_arb2 u_rr_arb2 (
        .req   ({dma_req, cpu_req}),
        .last  (r_last),
        .grant (w_grant),
        .valid (w_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignment so all flops update together at the edge.
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        cpu_ack      = 1'b0;
        dma_ack      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) w_next_state = SERVE;
            end
            SERVE: begin
                w_next_state = ACK;
                // The memory bus sees only latched values, never the live port inputs.
                if (!reset) begin
                    mem_we    = r_we;
                    mem_re    = ~r_we;
                    mem_addr  = r_addr;
                    mem_wdata = r_wdata;
                end
            end
            ACK: begin
                w_next_state = IDLE;
                if (!reset) begin
                    cpu_ack = (r_gnt == PORT_CPU);
                    dma_ack = (r_gnt == PORT_DMA);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last      <= PORT_DMA;
            r_gnt       <= PORT_CPU;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_gnt   <= w_grant;
                r_we    <= (w_grant == PORT_DMA) ? dma_we    : cpu_we;
                r_addr  <= (w_grant == PORT_DMA) ? dma_addr  : cpu_addr;
                r_wdata <= (w_grant == PORT_DMA) ? dma_wdata : cpu_wdata;
            end
            if (r_state == SERVE && !r_we) begin
                if (r_gnt == PORT_CPU) r_cpu_rdata <= mem_rdata;
                else                   r_dma_rdata <= mem_rdata;
            end
            if (r_state == ACK) r_last <= r_gnt;
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed cycle-exact scenarios,
// then random two-port traffic checked by a scoreboard and monitor.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p_req [2];
    logic       p_we [2];
    logic [7:0] p_addr [2];
    logic [7:0] p_wdata [2];
    logic       p_ack [2];
    logic [7:0] p_rdata [2];
    logic       cpu_ack, dma_ack;
    logic [7:0] cpu_rdata, dma_rdata;
    logic       mem_we, mem_re, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem_model [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] exp_rd [2];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } txn_t;

    txn_t sb_q0 [$];
    txn_t sb_q1 [$];

    logic       mon_en = 1'b0;
    logic       mon_last;
    logic       h1_we, h1_re;
    logic [7:0] h1_addr, h1_wdata;
    logic       h2_req [2];
    logic       h1_req [2];

    always #5 clk = ~clk;

    assign p_ack[0]   = cpu_ack;
    assign p_ack[1]   = dma_ack;
    assign p_rdata[0] = cpu_rdata;
    assign p_rdata[1] = dma_rdata;

    always @(posedge clk) if (mem_we) mem_model[mem_addr] <= mem_wdata;
    assign mem_rdata = mem_model[mem_addr];

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (p_req[0]),
        .cpu_we    (p_we[0]),
        .cpu_addr  (p_addr[0]),
        .cpu_wdata (p_wdata[0]),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dma_req   (p_req[1]),
        .dma_we    (p_we[1]),
        .dma_addr  (p_addr[1]),
        .dma_wdata (p_wdata[1]),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) p_req[i] = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_acks", {cpu_ack, dma_ack}, 0);
        check("rst_mem_en", {mem_we, mem_re}, 0);
        tick();
        reset = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge clk);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    endtask

    // One isolated access on port p, checked cycle by cycle through the ack.
    task automatic single_access(input int p, input logic we, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_data);
        int o;
        o = 1 - p;
        tick();
        p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = addr; p_wdata[p] = wdata;
        if (we) ref_mem[addr] = wdata;
        else    exp_rd[p] = exp_data;
        @(negedge clk);
        check("c1_busy", busy, 0);
        check("c1_mem_en", {mem_we, mem_re}, 0);
        tick();
        @(negedge clk);
        check("c2_busy", busy, 1);
        check("c2_mem_we", mem_we, we);
        check("c2_mem_re", mem_re, !we);
        check("c2_mem_addr", mem_addr, addr);
        if (we) check("c2_mem_wdata", mem_wdata, wdata);
        check("c2_acks", {cpu_ack, dma_ack}, 0);
        tick();
        @(negedge clk);
        check("c3_ack", p_ack[p], 1);
        check("c3_other_ack", p_ack[o], 0);
        check("c3_busy", busy, 1);
        check("c3_mem_idle", {mem_we, mem_re, mem_addr, mem_wdata}, 0);
        check("c3_rdata", p_rdata[p], exp_rd[p]);
        check("c3_other_rdata", p_rdata[o], exp_rd[o]);
        tick();
        p_req[p] = 1'b0;
        @(negedge clk);
        check("c4_busy", busy, 0);
        check("c4_acks", {cpu_ack, dma_ack}, 0);
    endtask

    // Random requester: one outstanding access at a time, addresses confined
    // to its own half of memory so the reference stays order-independent.
    task automatic port_driver(input int p, input int ntx);
        logic [7:0] cur_rd;
        txn_t       t;
        logic       got;
        cur_rd = 8'h00;
        for (int n = 0; n < ntx; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            t.we    = 1'($urandom_range(0, 1));
            t.addr  = {p[0], 7'($urandom)};
            t.wdata = 8'($urandom);
            if (t.we) ref_mem[t.addr] = t.wdata;
            else      cur_rd = ref_mem[t.addr];
            t.rdata = cur_rd;
            if (p == 0) sb_q0.push_back(t);
            else        sb_q1.push_back(t);
            p_req[p] = 1'b1; p_we[p] = t.we; p_addr[p] = t.addr; p_wdata[p] = t.wdata;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                got = p_ack[p];
            end
            check("ack_within_budget", got, 1);
            tick();
            p_req[p] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            txn_t e;
            int   p;
            check("bus_then_ack", h1_we | h1_re, cpu_ack | dma_ack);
            if (!mem_we && !mem_re) check("idle_bus_zero", {mem_addr, mem_wdata}, 0);
            if (cpu_ack || dma_ack) begin
                check("single_ack", cpu_ack & dma_ack, 0);
                p = dma_ack ? 1 : 0;
                check("ack_expected", (p == 0) ? sb_q0.size() : sb_q1.size(), 1);
                if (((p == 0) ? sb_q0.size() : sb_q1.size()) != 0) begin
                    e = (p == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
                    check("sb_mem_we", h1_we, e.we);
                    check("sb_mem_re", h1_re, !e.we);
                    check("sb_mem_addr", h1_addr, e.addr);
                    if (e.we) check("sb_mem_wdata", h1_wdata, e.wdata);
                    check("sb_rdata", p_rdata[p], e.rdata);
                end
                check("req_at_grant", h2_req[p], 1);
                if (h2_req[0] && h2_req[1]) check("rr_winner", p, 32'(!mon_last));
                mon_last = p[0];
            end
            h2_req[0] = h1_req[0];
            h2_req[1] = h1_req[1];
            h1_req[0] = p_req[0];
            h1_req[1] = p_req[1];
            h1_we = mem_we; h1_re = mem_re; h1_addr = mem_addr; h1_wdata = mem_wdata;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        logic got;
        for (int i = 0; i < 2; i++) begin
            p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = 8'h00; p_wdata[i] = 8'h00;
        end

        // Write then read back on the cpu port.
        do_reset();
        single_access(0, 1'b1, 8'h10, 8'hA5, 8'h00);
        single_access(0, 1'b0, 8'h10, 8'h00, 8'hA5);

        // Both ports requesting from reset: grants alternate cpu, dma, ...
        tick();
        reset = 1'b1;
        p_req[0] = 1'b1; p_we[0] = 1'b1; p_addr[0] = 8'h20; p_wdata[0] = 8'h01;
        p_req[1] = 1'b1; p_we[1] = 1'b1; p_addr[1] = 8'h21; p_wdata[1] = 8'h02;
        ref_mem[8'h20] = 8'h01;
        ref_mem[8'h21] = 8'h02;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("alt_cpu_ack", cpu_ack, (k % 3 == 0) && ((k / 3) % 2 == 1));
            check("alt_dma_ack", dma_ack, (k % 3 == 0) && ((k / 3) % 2 == 0));
            tick();
        end
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;

        // dma reads what cpu wrote while cpu stays idle.
        single_access(1, 1'b0, 8'h20, 8'h00, 8'h01);

        // Reset during SERVE of a cpu read discards it.
        single_access(0, 1'b0, 8'h21, 8'h00, 8'h02);
        tick();
        p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 8'h20;
        @(negedge clk);
        check("int_c1_ack", cpu_ack, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("int_rst_mem_en", {mem_we, mem_re}, 0);
        check("int_rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        p_req[0] = 1'b0;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        @(negedge clk);
        check("int_no_ack", {cpu_ack, dma_ack}, 0);
        check("int_idle", busy, 0);
        check("int_cpu_rdata", cpu_rdata, 0);
        check("int_dma_rdata", dma_rdata, 0);
        tick();
        p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 8'h10;
        p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 8'h21;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("post_rst_first_addr", mem_addr, 8'h10);
        tick();
        @(negedge clk);
        check("post_rst_cpu_ack", cpu_ack, 1);
        check("post_rst_dma_ack", dma_ack, 0);
        check("post_rst_cpu_rdata", cpu_rdata, 8'hA5);
        tick();
        p_req[0] = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 8 && !got) begin
            @(negedge clk);
            n++;
            got = dma_ack;
            if (!got) tick();
        end
        check("post_rst_dma_latency", n, 3);
        check("post_rst_dma_rdata", dma_rdata, 8'h02);
        tick();
        p_req[1] = 1'b0;

        // Random concurrent traffic against the scoreboard.
        do_reset();
        mon_last = 1'b1;
        h1_we = 1'b0; h1_re = 1'b0; h1_addr = 8'h00; h1_wdata = 8'h00;
        for (int i = 0; i < 2; i++) begin
            h1_req[i] = 1'b0;
            h2_req[i] = 1'b0;
        end
        mon_en = 1'b1;
        fork
            port_driver(0, 40);
            port_driver(1, 40);
        join
        repeat (4) tick();
        mon_en = 1'b0;
        check("sb_drained", sb_q0.size() + sb_q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
